// File: rtl/csi2_ecc_pkg.sv
// CSI-2 packet header ECC helpers: parity generator, header layout and
// the "no position" marker used with the syndrome lookup.
package csi2_ecc_pkg;

   localparam logic [4:0] NO_POS = 5'h1F;

   typedef struct packed {
      logic [7:0]  ecc;
      logic [15:0] wc;
      logic [7:0]  di;
   } csi2_hdr_t;

   // Each mask selects the data bits covered by parity bit P0..P5.
   function automatic logic [5:0] calc_ecc(input logic [23:0] d);
      logic [5:0] p;
      p[0] = ^(d & 24'hF12CB7);
      p[1] = ^(d & 24'hF2555B);
      p[2] = ^(d & 24'h749A6D);
      p[3] = ^(d & 24'hB8E38E);
      p[4] = ^(d & 24'hDF03F0);
      p[5] = ^(d & 24'hEFFC00);
      return p;
   endfunction

endpackage

// File: rtl/csi2_err_bit_pos_pkg.sv
// Syndrome-to-bit-position lookup for the CSI-2 24-bit header ECC.
// Entry [7:0] indexed by the 6-bit syndrome; [4:0] holds the data bit
// position (0..23) or 5'h1F when the syndrome does not name a data bit.
package csi2_err_bit_pos_pkg;

   localparam logic [7:0] ROM_INIT [64] = '{
      8'h1F, 8'h1F, 8'h1F, 8'h1F, 8'h1F, 8'h1F, 8'h1F, 8'h00,
      8'h1F, 8'h1F, 8'h1F, 8'h01, 8'h1F, 8'h02, 8'h03, 8'h1F,
      8'h1F, 8'h1F, 8'h1F, 8'h04, 8'h1F, 8'h05, 8'h06, 8'h1F,
      8'h1F, 8'h07, 8'h08, 8'h1F, 8'h09, 8'h1F, 8'h1F, 8'h14,
      8'h1F, 8'h1F, 8'h1F, 8'h0A, 8'h1F, 8'h0B, 8'h0C, 8'h1F,
      8'h1F, 8'h0D, 8'h0E, 8'h1F, 8'h0F, 8'h1F, 8'h1F, 8'h15,
      8'h1F, 8'h10, 8'h11, 8'h1F, 8'h12, 8'h1F, 8'h1F, 8'h16,
      8'h13, 8'h1F, 8'h1F, 8'h17, 8'h1F, 8'h1F, 8'h1F, 8'h1F
   };

endpackage

// File: rtl/csi2_sat_counter.sv
// Saturating event counter with synchronous clear.
// Ports: clk, rst (sync, active-high), clear (sync, wins over inc),
//        inc (count one event), cnt (current value, sticks at all-ones).
module csi2_sat_counter #(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear,
   input  logic                 inc,
   output logic [CNT_WIDTH-1:0] cnt
);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt <= '0;
      end else if (inc && (cnt != '1)) begin
         cnt <= cnt + CNT_WIDTH'(1);
      end
   end

endmodule

// File: rtl/csi2_hdr_ecc_corrector.sv
// CSI-2 packet header ECC checker/corrector, two-stage pipeline.
// S1 registers the header data and its syndrome; S2 holds the corrected
// header with a freshly generated ECC byte and the corr/uncorr flags.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   hdr_valid_i/ready_o/i   input header handshake, hdr_i = {ECC, WC, DI}
//   hdr_valid_o/ready_i     output header handshake, hdr_o corrected header
//   ecc_corr_o/uncorr_o     per-header flags qualifying hdr_o
//   cnt_clear_i             clears both statistics counters
//   corr_cnt_o/uncorr_cnt_o saturating corrected / uncorrectable counts
module csi2_hdr_ecc_corrector
   import csi2_ecc_pkg::*;
   import csi2_err_bit_pos_pkg::*;
#(
   parameter int CNT_WIDTH   = 16,
   parameter bit DROP_UNCORR = 1'b0
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 hdr_valid_i,
   output logic                 hdr_ready_o,
   input  logic [31:0]          hdr_i,
   output logic                 hdr_valid_o,
   input  logic                 hdr_ready_i,
   output logic [31:0]          hdr_o,
   output logic                 ecc_corr_o,
   output logic                 ecc_uncorr_o,
   input  logic                 cnt_clear_i,
   output logic [CNT_WIDTH-1:0] corr_cnt_o,
   output logic [CNT_WIDTH-1:0] uncorr_cnt_o
);

   logic        s1_valid;
   logic [23:0] s1_data;
   logic [5:0]  s1_syn;

   logic        s2_valid;
   csi2_hdr_t   s2_hdr;
   logic        s2_corr;
   logic        s2_uncorr;

   logic        s2_drop;
   logic        s2_done;
   logic        s2_accept;
   logic        s1_advance;
   logic        in_fire;

   logic [4:0]  pos;
   logic [23:0] fix_data;
   logic        fix_corr;
   logic        fix_uncorr;

   // ECC[7:6] are reserved and take no part in the check.
   logic        unused_rsvd;
   assign unused_rsvd = ^hdr_i[31:30];

   // An uncorrectable entry in drop mode retires without a beat.
   assign s2_drop     = DROP_UNCORR && s2_uncorr;
   assign hdr_valid_o = s2_valid && !s2_drop;
   assign s2_done     = s2_valid && (hdr_ready_i || s2_drop);
   assign s2_accept   = !s2_valid || s2_done;
   assign s1_advance  = s1_valid && s2_accept;
   assign hdr_ready_o = !s1_valid || s1_advance;
   assign in_fire     = hdr_valid_i && hdr_ready_o;

   always_comb begin
      pos        = ROM_INIT[s1_syn][4:0];
      fix_data   = s1_data;
      fix_corr   = 1'b0;
      fix_uncorr = 1'b0;
      if (s1_syn != 6'd0) begin
         if ((s1_syn & (s1_syn - 6'd1)) == 6'd0) begin
            // Single syndrome bit: the flipped bit was an ECC bit.
            fix_corr = 1'b1;
         end else if ((pos != NO_POS) && (pos < 5'd24)) begin
            fix_data = s1_data ^ (24'd1 << pos);
            fix_corr = 1'b1;
         end else begin
            fix_uncorr = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         s1_syn   <= '0;
      end else begin
         if (hdr_ready_o) begin
            s1_valid <= hdr_valid_i;
         end
         if (in_fire) begin
            s1_data <= hdr_i[23:0];
            s1_syn  <= calc_ecc(hdr_i[23:0]) ^ hdr_i[29:24];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s2_valid  <= 1'b0;
         s2_hdr    <= '0;
         s2_corr   <= 1'b0;
         s2_uncorr <= 1'b0;
      end else begin
         if (s2_accept) begin
            s2_valid <= s1_valid;
         end
         if (s1_advance) begin
            s2_hdr    <= '{ecc: {2'b00, calc_ecc(fix_data)},
                           wc:  fix_data[23:8],
                           di:  fix_data[7:0]};
            s2_corr   <= fix_corr;
            s2_uncorr <= fix_uncorr;
         end
      end
   end

   assign hdr_o        = s2_hdr;
   assign ecc_corr_o   = s2_corr;
   assign ecc_uncorr_o = s2_uncorr;

   // Counted on entry to S2 so an output stall never counts twice.
   csi2_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_corr_cnt (
      .clk   (clk_i),
      .rst   (rst_i),
      .clear (cnt_clear_i),
      .inc   (s1_advance && fix_corr),
      .cnt   (corr_cnt_o)
   );

   csi2_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_uncorr_cnt (
      .clk   (clk_i),
      .rst   (rst_i),
      .clear (cnt_clear_i),
      .inc   (s1_advance && fix_uncorr),
      .cnt   (uncorr_cnt_o)
   );

endmodule

// File: tb/tb_csi2_hdr_ecc_corrector.sv
module tb_csi2_hdr_ecc_corrector;

   typedef struct {
      logic [31:0] hdr;
      logic        corr;
      logic        uncorr;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // instance A: defaults; instance B: CNT_WIDTH=4, DROP_UNCORR=1
   logic        a_valid_i, a_ready_o, a_valid_o, a_ready_i, a_corr, a_uncorr, a_clr;
   logic [31:0] a_hdr_i, a_hdr_o;
   logic [15:0] a_corr_cnt, a_uncorr_cnt;
   logic        b_valid_i, b_ready_o, b_valid_o, b_ready_i, b_corr, b_uncorr, b_clr;
   logic [31:0] b_hdr_i, b_hdr_o;
   logic [3:0]  b_corr_cnt, b_uncorr_cnt;

   csi2_hdr_ecc_corrector dut_a (
      .clk_i(clk), .rst_i(rst),
      .hdr_valid_i(a_valid_i), .hdr_ready_o(a_ready_o), .hdr_i(a_hdr_i),
      .hdr_valid_o(a_valid_o), .hdr_ready_i(a_ready_i), .hdr_o(a_hdr_o),
      .ecc_corr_o(a_corr), .ecc_uncorr_o(a_uncorr), .cnt_clear_i(a_clr),
      .corr_cnt_o(a_corr_cnt), .uncorr_cnt_o(a_uncorr_cnt)
   );

   csi2_hdr_ecc_corrector #(.CNT_WIDTH(4), .DROP_UNCORR(1'b1)) dut_b (
      .clk_i(clk), .rst_i(rst),
      .hdr_valid_i(b_valid_i), .hdr_ready_o(b_ready_o), .hdr_i(b_hdr_i),
      .hdr_valid_o(b_valid_o), .hdr_ready_i(b_ready_i), .hdr_o(b_hdr_o),
      .ecc_corr_o(b_corr), .ecc_uncorr_o(b_uncorr), .cnt_clear_i(b_clr),
      .corr_cnt_o(b_corr_cnt), .uncorr_cnt_o(b_uncorr_cnt)
   );

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   a_beats = 0;
   int   b_beats = 0;
   bit   lat_chk = 1'b0;
   bit   rand_rdy = 1'b0;
   exp_t exp_a[$];
   exp_t exp_b[$];

   // syndrome contributed by each data bit (column view of the ECC matrix)
   localparam logic [5:0] COL [24] = '{
      6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
      6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
      6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B
   };

   function automatic logic [5:0] ecc_of(input logic [23:0] d);
      logic [5:0] s = 6'd0;
      for (int i = 0; i < 24; i++) if (d[i]) s ^= COL[i];
      return s;
   endfunction

   function automatic logic [31:0] mk(input logic [23:0] d);
      return {2'b00, ecc_of(d), d};
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      if (rand_rdy) a_ready_i = 1'($urandom_range(1));
   end

   // output monitors / scoreboard checkers
   bit          a_stall = 1'b0, b_stall = 1'b0;
   logic [31:0] a_hold, b_hold;

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         a_stall = 1'b0;
      end else begin
         if (a_stall) begin
            total++;
            if (a_valid_o !== 1'b1 || a_hdr_o !== a_hold) begin
               bad++;
               $display("FAIL stall_hold_a: valid=%b hdr=%h, want valid=1 hdr=%h", a_valid_o, a_hdr_o, a_hold);
            end
         end
         if (a_valid_o && a_ready_i) begin
            a_beats++;
            total++;
            if (exp_a.size() == 0) begin
               bad++;
               $display("FAIL unexpected_beat_a: hdr=%h, want no beat", a_hdr_o);
            end else begin
               e = exp_a.pop_front();
               if ({a_hdr_o, a_corr, a_uncorr} !== {e.hdr, e.corr, e.uncorr}) begin
                  bad++;
                  $display("FAIL beat_a: hdr=%h corr=%b uncorr=%b, want hdr=%h corr=%b uncorr=%b",
                           a_hdr_o, a_corr, a_uncorr, e.hdr, e.corr, e.uncorr);
               end
               if (lat_chk) begin
                  total++;
                  if (cyc - e.cyc != 2) begin
                     bad++;
                     $display("FAIL latency_a: got %0d cycles, want 2", cyc - e.cyc);
                  end
               end
            end
         end
         a_stall = a_valid_o && !a_ready_i;
         a_hold  = a_hdr_o;
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         b_stall = 1'b0;
      end else begin
         if (b_stall) begin
            total++;
            if (b_valid_o !== 1'b1 || b_hdr_o !== b_hold) begin
               bad++;
               $display("FAIL stall_hold_b: valid=%b hdr=%h, want valid=1 hdr=%h", b_valid_o, b_hdr_o, b_hold);
            end
         end
         if (b_valid_o && b_ready_i) begin
            b_beats++;
            total++;
            if (exp_b.size() == 0) begin
               bad++;
               $display("FAIL unexpected_beat_b: hdr=%h, want no beat", b_hdr_o);
            end else begin
               e = exp_b.pop_front();
               if ({b_hdr_o, b_corr, b_uncorr} !== {e.hdr, e.corr, e.uncorr}) begin
                  bad++;
                  $display("FAIL beat_b: hdr=%h corr=%b uncorr=%b, want hdr=%h corr=%b uncorr=%b",
                           b_hdr_o, b_corr, b_uncorr, e.hdr, e.corr, e.uncorr);
               end
            end
         end
         b_stall = b_valid_o && !b_ready_i;
         b_hold  = b_hdr_o;
      end
   end

   // drive one header, push the expectation when it is accepted
   task automatic send(input bit to_b, input logic [31:0] h, input logic [31:0] eh,
                       input logic ec, input logic eu, input bit expect_out);
      exp_t e;
      bit   rdy = 1'b0;
      int   n = 0;
      e.hdr = eh; e.corr = ec; e.uncorr = eu; e.cyc = 0;
      if (to_b) begin b_valid_i = 1'b1; b_hdr_i = h; end
      else      begin a_valid_i = 1'b1; a_hdr_i = h; end
      while (!rdy && n < 200) begin
         @(negedge clk);
         rdy = to_b ? b_ready_o : a_ready_o;
         n++;
      end
      if (!rdy) begin
         total++; bad++;
         $display("FAIL accept_timeout: ready low for %0d cycles, want accept", n);
      end else begin
         e.cyc = cyc;
         if (expect_out) begin
            if (to_b) exp_b.push_back(e); else exp_a.push_back(e);
         end
      end
      @(posedge clk); #1;
      if (to_b) b_valid_i = 1'b0; else a_valid_i = 1'b0;
   endtask

   task automatic drain(input bit to_b);
      int n = 0;
      while ((to_b ? exp_b.size() : exp_a.size()) != 0 && n < 500) begin
         @(negedge clk); n++;
      end
      repeat (3) @(negedge clk);
      total++;
      if ((to_b ? exp_b.size() : exp_a.size()) != 0) begin
         bad++;
         $display("FAIL drain_%s: %0d headers pending, want 0", to_b ? "b" : "a",
                  to_b ? exp_b.size() : exp_a.size());
      end
      @(posedge clk); #1;
   endtask

   localparam logic [23:0] BASE = 24'h0F002B;

   task automatic test_reset();
      @(negedge clk);
      total++;
      if ({a_valid_o, a_hdr_o, a_corr, a_uncorr, a_ready_o, a_corr_cnt, a_uncorr_cnt} !==
          {1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0}) begin
         bad++;
         $display("FAIL reset_a: valid=%b hdr=%h flags=%b%b ready=%b cnt=%h/%h, want 0/0/00/1/0/0",
                  a_valid_o, a_hdr_o, a_corr, a_uncorr, a_ready_o, a_corr_cnt, a_uncorr_cnt);
      end
      total++;
      if ({b_valid_o, b_hdr_o, b_corr, b_uncorr, b_ready_o, b_corr_cnt, b_uncorr_cnt} !==
          {1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0}) begin
         bad++;
         $display("FAIL reset_b: valid=%b hdr=%h flags=%b%b ready=%b cnt=%h/%h, want 0/0/00/1/0/0",
                  b_valid_o, b_hdr_o, b_corr, b_uncorr, b_ready_o, b_corr_cnt, b_uncorr_cnt);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_clean_stream();
      lat_chk = 1'b1;
      for (int i = 0; i < 100; i++) send(1'b0, mk(BASE), mk(BASE), 1'b0, 1'b0, 1'b1);
      drain(1'b0);
      lat_chk = 1'b0;
      total++;
      if (a_corr_cnt !== 16'd0 || a_uncorr_cnt !== 16'd0) begin
         bad++;
         $display("FAIL clean_counts: corr=%0d uncorr=%0d, want 0 0", a_corr_cnt, a_uncorr_cnt);
      end
   endtask

   task automatic test_data_bit_sweep();
      for (int b = 0; b < 24; b++) send(1'b0, mk(BASE) ^ (32'd1 << b), mk(BASE), 1'b1, 1'b0, 1'b1);
      drain(1'b0);
      total++;
      if (a_corr_cnt !== 16'd24) begin
         bad++;
         $display("FAIL sweep_corr_cnt: got %0d, want 24", a_corr_cnt);
      end
   endtask

   task automatic test_ecc_bits();
      for (int b = 24; b < 30; b++) send(1'b0, mk(BASE) ^ (32'd1 << b), mk(BASE), 1'b1, 1'b0, 1'b1);
      send(1'b0, mk(BASE) ^ 32'h4000_0000, mk(BASE), 1'b0, 1'b0, 1'b1);
      send(1'b0, mk(BASE) ^ 32'h8000_0000, mk(BASE), 1'b0, 1'b0, 1'b1);
      send(1'b0, mk(BASE) ^ 32'hC000_0000, mk(BASE), 1'b0, 1'b0, 1'b1);
      drain(1'b0);
      total++;
      if (a_corr_cnt !== 16'd30 || a_uncorr_cnt !== 16'd0) begin
         bad++;
         $display("FAIL ecc_bit_counts: corr=%0d uncorr=%0d, want 30 0", a_corr_cnt, a_uncorr_cnt);
      end
   endtask

   task automatic test_double_bit();
      logic [31:0] h;
      int          beats0;
      h = mk(BASE) ^ 32'h0002_0008;
      send(1'b0, h, mk(h[23:0]), 1'b0, 1'b1, 1'b1);
      drain(1'b0);
      total++;
      if (a_uncorr_cnt !== 16'd1) begin
         bad++;
         $display("FAIL double_uncorr_cnt: got %0d, want 1", a_uncorr_cnt);
      end
      b_ready_i = 1'b1;
      beats0 = b_beats;
      send(1'b1, h, 32'h0, 1'b0, 1'b1, 1'b0);
      repeat (6) @(negedge clk);
      total++;
      if (b_beats != beats0 || b_uncorr_cnt !== 4'd1) begin
         bad++;
         $display("FAIL drop_uncorr: beats=%0d cnt=%0d, want beats=%0d cnt=1", b_beats, b_uncorr_cnt, beats0);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure();
      logic [23:0] d;
      logic [31:0] h;
      int          kind;
      int          n_corr = 0;
      a_clr = 1'b1;
      @(posedge clk); #1;
      a_clr = 1'b0;
      total++;
      if (a_corr_cnt !== 16'd0 || a_uncorr_cnt !== 16'd0) begin
         bad++;
         $display("FAIL clear_a: corr=%0d uncorr=%0d, want 0 0", a_corr_cnt, a_uncorr_cnt);
      end
      rand_rdy = 1'b1;
      for (int i = 0; i < 10000; i++) begin
         if ($urandom_range(1) == 0) begin @(posedge clk); #1; end
         d = 24'($urandom);
         h = mk(d);
         h[31:30] = 2'($urandom_range(3));
         kind = $urandom_range(2);
         if (kind == 1) h = h ^ (32'd1 << $urandom_range(23));
         if (kind == 2) h = h ^ (32'd1 << (24 + $urandom_range(5)));
         if (kind != 0) n_corr++;
         send(1'b0, h, mk(d), kind != 0, 1'b0, 1'b1);
      end
      rand_rdy = 1'b0;
      a_ready_i = 1'b1;
      drain(1'b0);
      total++;
      if (a_corr_cnt !== 16'(n_corr) || a_uncorr_cnt !== 16'd0) begin
         bad++;
         $display("FAIL bp_counts: corr=%0d uncorr=%0d, want %0d 0", a_corr_cnt, a_uncorr_cnt, n_corr);
      end
   endtask

   task automatic test_counter_edges();
      logic [31:0] h;
      h = mk(BASE) ^ 32'h0000_0100;
      b_ready_i = 1'b1;
      b_clr = 1'b1;
      @(posedge clk); #1;
      b_clr = 1'b0;
      total++;
      if (b_uncorr_cnt !== 4'd0) begin
         bad++;
         $display("FAIL clear_b: uncorr=%0d, want 0", b_uncorr_cnt);
      end
      send(1'b1, h, mk(BASE), 1'b1, 1'b0, 1'b1);
      send(1'b1, h, mk(BASE), 1'b1, 1'b0, 1'b1);
      drain(1'b1);
      total++;
      if (b_corr_cnt !== 4'd2) begin
         bad++;
         $display("FAIL corr_cnt_b_two: got %0d, want 2", b_corr_cnt);
      end
      send(1'b1, h, mk(BASE), 1'b1, 1'b0, 1'b1);
      b_clr = 1'b1;
      @(posedge clk); #1;
      b_clr = 1'b0;
      total++;
      if (b_corr_cnt !== 4'd0) begin
         bad++;
         $display("FAIL clear_vs_inc: got %0d, want 0", b_corr_cnt);
      end
      drain(1'b1);
      for (int i = 0; i < 20; i++) send(1'b1, h, mk(BASE), 1'b1, 1'b0, 1'b1);
      drain(1'b1);
      total++;
      if (b_corr_cnt !== 4'd15) begin
         bad++;
         $display("FAIL saturate: got %0d, want 15", b_corr_cnt);
      end
   endtask

   task automatic test_reset_in_flight();
      logic [31:0] h;
      h = mk(BASE) ^ 32'h0000_1000;
      a_ready_i = 1'b0;
      send(1'b0, h, mk(BASE), 1'b1, 1'b0, 1'b1);
      send(1'b0, h, mk(BASE), 1'b1, 1'b0, 1'b1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_a.delete();
      a_ready_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         total++;
         if (a_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL inflight_valid: got %b, want 0", a_valid_o);
         end
      end
      total++;
      if (a_corr_cnt !== 16'd0 || a_uncorr_cnt !== 16'd0) begin
         bad++;
         $display("FAIL inflight_counts: corr=%0d uncorr=%0d, want 0 0", a_corr_cnt, a_uncorr_cnt);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1;
      a_valid_i = 1'b0; a_hdr_i = '0; a_ready_i = 1'b1; a_clr = 1'b0;
      b_valid_i = 1'b0; b_hdr_i = '0; b_ready_i = 1'b1; b_clr = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      test_reset();
      test_clean_stream();
      test_data_bit_sweep();
      test_ecc_bits();
      test_double_bit();
      test_backpressure();
      test_counter_edges();
      test_reset_in_flight();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
